// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the memory-stage sequencer and the memory.
// The controller drives the request side; the memory returns ack and read data.
interface mem_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MIPS memory-stage sequencer: runs a req/ack data-memory transaction,
// stalls the pipeline while it is pending, and returns load data or an error.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    mem_access_ctrl_if.master         bus,
    output logic [31:0]               rdata,
    output logic                      rdata_valid,
    output logic                      stall,
    output logic                      bus_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             bus_err_q, bus_err_d;
    logic             err_q, err_d;

    logic             req;
    logic             misaligned;
    logic [CNT_W-1:0] cnt_inc;

    assign req        = mem_read | mem_write;
    assign misaligned = addr[1:0] != 2'b00;
    assign cnt_inc    = cnt_q + CNT_W'(1);

    // Pipeline freeze: decided in IDLE from the live request, held through BUSY.
    assign stall = ~reset & (((state_q == IDLE) & req) | (state_q == BUSY));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        bus_err_d     = 1'b0;
        err_d         = err_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    bus_addr_d  = addr;
                    bus_wdata_d = wdata;
                    bus_we_d    = mem_write;
                    cnt_d       = '0;
                    if (misaligned) begin
                        bus_err_d = 1'b1;
                        err_d     = 1'b1;
                        state_d   = DONE;
                    end else begin
                        bus_req_d = 1'b1;
                        err_d     = mem_read & mem_write;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.bus_ack) begin
                    if (!bus_we_q) begin
                        rdata_d       = bus.bus_rdata;
                        rdata_valid_d = ~err_q;
                    end
                    bus_err_d = err_q;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    // Abort once the access has spent TIMEOUT cycles without ack.
                    if (cnt_inc == TIMEOUT_C) begin
                        bus_req_d = 1'b0;
                        bus_err_d = 1'b1;
                        err_d     = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                bus_req_d = 1'b0;
                err_d     = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            bus_err_q     <= bus_err_d;
            err_q         <= err_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign rdata         = rdata_q;
    assign rdata_valid   = rdata_valid_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a vector table of whole accesses scored through a
// queue, plus hand sequences for reset, back-to-back and spurious-ack cases.
module tb_mem_access_ctrl;

    localparam int unsigned TO = 4;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int unsigned dly;      // BUSY cycle in which memory acks; 0 = never
        int unsigned stalls;
        int unsigned reqs;
        logic        err;
        logic        valid;
        logic [31:0] rdata;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        stall;
    logic        bus_err;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr        (addr),
        .wdata       (wdata),
        .bus         (bus),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .bus_err     (bus_err)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    vec_t exp_q[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drive one access starting at a negedge; ends on the negedge after the post-DONE cycle.
    task automatic run_vec(input int idx, input vec_t v);
        vec_t        e;
        int unsigned stalls = 0;
        int unsigned reqs   = 0;
        int unsigned busy   = 0;
        logic        done   = 1'b0;
        logic        bus_ok = 1'b1;
        logic        err_s  = 1'b0;
        logic        val_s  = 1'b0;
        logic [31:0] rd_s   = '0;
        string       tag;
        tag = $sformatf("v%0d", idx);
        exp_q.push_back(v);
        mem_read      = v.rd;
        mem_write     = v.wr;
        addr          = v.addr;
        wdata         = v.wdata;
        bus.bus_rdata = v.mdata;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (stall) stalls++;
            if (bus.bus_req) begin
                reqs++;
                busy++;
                if (bus.bus_we !== v.wr || bus.bus_addr !== v.addr ||
                    (v.wr && bus.bus_wdata !== v.wdata))
                    bus_ok = 1'b0;
            end
            bus.bus_ack = bus.bus_req && (busy == v.dly);
            if (c > 0 && !stall) begin
                done      = 1'b1;
                err_s     = bus_err;
                val_s     = rdata_valid;
                rd_s      = rdata;
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            @(negedge clock);
        end
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        bus.bus_ack = 1'b0;
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        e = exp_q.pop_front();
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(e.stalls));
        chk({tag, "_req_cycles"},   32'(reqs),   32'(e.reqs));
        chk({tag, "_bus_fields"},   32'(bus_ok), 32'd1);
        chk({tag, "_bus_err"},      32'(err_s),  32'(e.err));
        chk({tag, "_rdata_valid"},  32'(val_s),  32'(e.valid));
        chk({tag, "_rdata"},        rd_s,        e.rdata);
        #1;
        chk({tag, "_post_pulses"}, {30'd0, rdata_valid, bus_err}, 32'd0);
        chk({tag, "_post_idle"},   {30'd0, stall, bus.bus_req}, 32'd0);
        @(negedge clock);
    endtask

    initial begin
        // rd, wr, addr, wdata, mdata, dly, stalls, reqs, err, valid, rdata
        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'h0,         0, 0, 0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEADBEEF,  3, 4, 3, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'h20, 32'h12345678,  32'hFFFFFFFF,  1, 2, 1, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h30, 32'h0,         32'hCCCCCCCC,  0, 5, 4, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b0, 32'h13, 32'h0,         32'hCCCCCCCC,  1, 1, 0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b1, 32'h40, 32'hA5A5A5A5,  32'h77777777,  2, 3, 2, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b0, 32'h44, 32'h0,         32'h0BADF00D,  1, 2, 1, 1'b0, 1'b1, 32'h0BADF00D};
        vecs[7] = '{1'b1, 1'b0, 32'h48, 32'h0,         32'h600DCAFE,  4, 5, 4, 1'b0, 1'b1, 32'h600DCAFE};
        vecs[8] = '{1'b0, 1'b1, 32'h22, 32'h55555555,  32'h0,         1, 1, 0, 1'b1, 1'b0, 32'h600DCAFE};

        reset         = 1'b1;
        mem_read      = 1'b1;
        mem_write     = 1'b0;
        addr          = 32'h10;
        wdata         = 32'h0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;

        // Reset for two edges with a request present: stall must stay low.
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_outs", {28'd0, bus.bus_req, bus.bus_we, rdata_valid, bus_err}, 32'd0);
        chk("rst_addr", bus.bus_addr, 32'd0);
        chk("rst_wdata", bus.bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset    = 1'b0;
        mem_read = 1'b0;
        @(negedge clock);
        #1;
        chk("idle_outs", {29'd0, stall, bus.bus_req, rdata_valid}, 32'd0);
        @(negedge clock);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Back-to-back loads: one dead cycle between bus requests.
        mem_read      = 1'b1;
        addr          = 32'h50;
        bus.bus_rdata = 32'h50505050;
        #1;
        chk("b2b_idle_stall", 32'(stall), 32'd1);
        @(negedge clock);
        #1;
        chk("b2b_req1", 32'(bus.bus_req), 32'd1);
        bus.bus_ack = 1'b1;
        @(negedge clock);
        bus.bus_ack = 1'b0;
        #1;
        chk("b2b_done1", {30'd0, stall, rdata_valid}, 32'd1);
        chk("b2b_rdata1", rdata, 32'h50505050);
        @(negedge clock);
        addr          = 32'h54;
        bus.bus_rdata = 32'h54545454;
        #1;
        chk("b2b_dead", {30'd0, stall, bus.bus_req}, 32'd2);
        @(negedge clock);
        #1;
        chk("b2b_req2", 32'(bus.bus_req), 32'd1);
        chk("b2b_addr2", bus.bus_addr, 32'h54);
        bus.bus_ack = 1'b1;
        @(negedge clock);
        bus.bus_ack = 1'b0;
        mem_read    = 1'b0;
        #1;
        chk("b2b_done2", {30'd0, stall, rdata_valid}, 32'd1);
        chk("b2b_rdata2", rdata, 32'h54545454);
        @(negedge clock);

        // Reset in the 2nd BUSY cycle coinciding with an ack.
        mem_read      = 1'b1;
        addr          = 32'h60;
        bus.bus_rdata = 32'h11111111;
        @(negedge clock);
        #1;
        chk("rb_busy1", 32'(bus.bus_req), 32'd1);
        @(negedge clock);
        reset       = 1'b1;
        bus.bus_ack = 1'b1;
        @(negedge clock);
        #1;
        chk("rb_req_drop", {30'd0, stall, bus.bus_req}, 32'd0);
        chk("rb_pulses", {30'd0, rdata_valid, bus_err}, 32'd0);
        reset       = 1'b0;
        mem_read    = 1'b0;
        bus.bus_ack = 1'b0;
        @(negedge clock);
        #1;
        chk("rb_after", {29'd0, stall, rdata_valid, bus_err}, 32'd0);
        chk("rb_rdata", rdata, 32'd0);

        // Spurious ack while idle.
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h99999999;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            #1;
            chk($sformatf("spur_%0d", k), {28'd0, stall, bus.bus_req, rdata_valid, bus_err}, 32'd0);
            chk($sformatf("spur_rdata_%0d", k), rdata, 32'd0);
        end
        bus.bus_ack = 1'b0;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
